dispensador_salida: RTL and testbench

//  Receiving end of the vending FSM result interface (listo/producto/cambio).

---
 rtl/dispensador_salida.sv | 130 +++++++++++++
 tb/tb_dispensador_salida.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dispensador_salida.sv
// Output dispenser: turns one completed sale into a timed motor run plus a coin-return pulse train.
// Optional motor-jam detection is compiled in with `define JAM_DETECT_EN.
module dispensador_salida #(
   parameter int MOTOR_CYCLES = 8,
   parameter int PULSE_HIGH   = 2,
   parameter int PULSE_LOW    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       listo,
   input  logic [1:0] producto,
   input  logic [1:0] cambio,
`ifdef JAM_DETECT_EN
   input  logic       motor_home,
`endif
   output logic       motor_on,
   output logic [1:0] motor_sel,
   output logic       coin_pulse,
   output logic       busy,
   output logic       done,
   output logic       overrun,
   output logic       jam
);

   localparam int MAX_AB = (MOTOR_CYCLES > PULSE_HIGH) ? MOTOR_CYCLES : PULSE_HIGH;
   localparam int MAX_C  = (MAX_AB > PULSE_LOW) ? MAX_AB : PULSE_LOW;
   localparam int CW     = $clog2(MAX_C + 1);

   typedef enum logic [2:0] {
      IDLE, MOTOR, COIN_HI, COIN_LO, DONE
`ifdef JAM_DETECT_EN
      , JAM
`endif
   } state_t;

   state_t          state, st_n;
   logic            listo_q;
   logic            armed;
   logic [1:0]      prod_r;
   logic [1:0]      coins_r;
   logic [CW-1:0]   cnt;
   logic            ev;

   // A listo held high across reset must not start a sale: require one low sample first.
   assign ev = listo & ~listo_q & armed;

`ifdef JAM_DETECT_EN
   logic seen_home;
`else
   assign jam = 1'b0;
`endif

   always_comb begin
      st_n = state;
      case (state)
         IDLE:
            if (ev) begin
               if (producto != 2'b00)    st_n = MOTOR;
               else if (cambio != 2'b00) st_n = COIN_HI;
               else                      st_n = DONE;
            end
         MOTOR:
            if (cnt == CW'(MOTOR_CYCLES - 1)) begin
`ifdef JAM_DETECT_EN
               if (!(seen_home || motor_home)) st_n = JAM;
               else st_n = (coins_r != 2'b00) ? COIN_HI : DONE;
`else
               st_n = (coins_r != 2'b00) ? COIN_HI : DONE;
`endif
            end
         COIN_HI:
            if (cnt == CW'(PULSE_HIGH - 1)) st_n = COIN_LO;
         COIN_LO:
            if (cnt == CW'(PULSE_LOW - 1))
               st_n = (coins_r != 2'b00) ? COIN_HI : DONE;
         DONE:
            st_n = IDLE;
`ifdef JAM_DETECT_EN
         JAM:
            st_n = JAM;
`endif
         default:
            st_n = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with the registered state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         listo_q    <= 1'b0;
         armed      <= 1'b0;
         prod_r     <= 2'b00;
         coins_r    <= 2'b00;
         cnt        <= '0;
         motor_on   <= 1'b0;
         motor_sel  <= 2'b00;
         coin_pulse <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         overrun    <= 1'b0;
`ifdef JAM_DETECT_EN
         jam        <= 1'b0;
         seen_home  <= 1'b0;
`endif
      end else begin
         listo_q <= listo;
         armed   <= armed | ~listo;
         state   <= st_n;
         cnt     <= (st_n != state) ? '0 : cnt + CW'(1);
         if (state == IDLE && ev) begin
            prod_r  <= producto;
            coins_r <= cambio;
         end else if (state == COIN_HI && st_n == COIN_LO) begin
            coins_r <= coins_r - 2'd1;
         end
         motor_on   <= (st_n == MOTOR);
         motor_sel  <= (st_n == MOTOR) ? ((state == IDLE) ? producto : prod_r) : 2'b00;
         coin_pulse <= (st_n == COIN_HI);
         busy       <= (st_n != IDLE);
         done       <= (st_n == DONE);
         overrun    <= ev && (state != IDLE);
`ifdef JAM_DETECT_EN
         jam        <= (st_n == JAM);
         seen_home  <= (state == MOTOR) && (seen_home || motor_home);
`endif
      end
   end

endmodule

// File: tb/tb_dispensador_salida.sv
// Directed bench for dispensador_salida: per-transaction scoreboard plus reset/overrun spot checks.
// Covers the JAM_DETECT_EN path when that macro is defined.
module tb_dispensador_salida;

   localparam int MC = 8;
   localparam int PH = 2;
   localparam int PL = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       listo;
   logic [1:0] producto;
   logic [1:0] cambio;
   logic       motor_home;
   logic       motor_on;
   logic [1:0] motor_sel;
   logic       coin_pulse;
   logic       busy;
   logic       done;
   logic       overrun;
   logic       jam;

   dispensador_salida #(.MOTOR_CYCLES(MC), .PULSE_HIGH(PH), .PULSE_LOW(PL)) dut (
      .clk(clk),
      .rst(rst),
      .listo(listo),
      .producto(producto),
      .cambio(cambio),
`ifdef JAM_DETECT_EN
      .motor_home(motor_home),
`endif
      .motor_on(motor_on),
      .motor_sel(motor_sel),
      .coin_pulse(coin_pulse),
      .busy(busy),
      .done(done),
      .overrun(overrun),
      .jam(jam)
   );

   always #5 clk = ~clk;

   typedef struct {
      int busy_len;
      int motor_len;
      int pulses;
      int sel;
   } txn_t;

   txn_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Monitor: accumulate what the DUT did during one busy window, compare on done.
   int   busy_n, mot_n, pul_n, sel_seen;
   int   sel_bad;
   logic coin_q;
   txn_t e;

   always @(negedge clk) begin
      if (rst) begin
         busy_n = 0; mot_n = 0; pul_n = 0; sel_seen = 0; sel_bad = 0; coin_q = 1'b0;
      end else begin
         if (busy) busy_n++;
         if (motor_on) begin
            mot_n++;
            if (mot_n == 1) sel_seen = int'(motor_sel);
            else if (int'(motor_sel) != sel_seen) sel_bad = 1;
         end else if (motor_sel != 2'b00) begin
            sel_bad = 1;
         end
         if (coin_pulse && !coin_q) pul_n++;
         coin_q = coin_pulse;
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("busy_len", busy_n, e.busy_len);
               chk("motor_len", mot_n, e.motor_len);
               chk("coin_pulses", pul_n, e.pulses);
               chk("motor_sel", sel_seen, e.sel);
               chk("sel_stable", sel_bad, 0);
            end
            busy_n = 0; mot_n = 0; pul_n = 0; sel_seen = 0; sel_bad = 0;
         end
      end
   end

   function automatic txn_t expect_of(input logic [1:0] p, input logic [1:0] c);
      txn_t t;
      t.motor_len = (p != 2'b00) ? MC : 0;
      t.pulses    = int'(c);
      t.busy_len  = t.motor_len + int'(c) * (PH + PL) + 1;
      t.sel       = (p != 2'b00) ? int'(p) : 0;
      return t;
   endfunction

   // One-cycle listo pulse; returns on the first cycle the DUT is busy.
   task automatic start(input logic [1:0] p, input logic [1:0] c);
      @(negedge clk);
      producto = p;
      cambio   = c;
      listo    = 1'b1;
      sb.push_back(expect_of(p, c));
      @(negedge clk);
      listo    = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("idle_timeout", 1, 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_seen;
      rst = 1'b1; listo = 1'b0; producto = 2'b00; cambio = 2'b00; motor_home = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_outputs", int'({motor_on, motor_sel, coin_pulse, busy, done, overrun, jam}), 0);
      rst = 1'b0;
      @(negedge clk);

      // motor only
      start(2'b01, 2'd0);
      wait_idle();

      // motor plus three coins
      start(2'b10, 2'd3);
      wait_idle();

      // coins only, then an empty sale
      start(2'b00, 2'd2);
      wait_idle();
      start(2'b00, 2'd0);
      wait_idle();

      // second edge during MOTOR is dropped and flagged
      @(negedge clk);
      producto = 2'b10; cambio = 2'd3; listo = 1'b1;
      sb.push_back(expect_of(2'b10, 2'd3));
      @(negedge clk);
      @(negedge clk);
      listo = 1'b0;
      @(negedge clk);
      listo = 1'b1; producto = 2'b01; cambio = 2'd0;
      @(negedge clk);
      chk("overrun_strobe", int'(overrun), 1);
      @(negedge clk);
      chk("overrun_one_cycle", int'(overrun), 0);
      listo = 1'b0;
      wait_idle();

      // reset mid-run with listo held high; no restart until listo falls
      @(negedge clk);
      producto = 2'b01; cambio = 2'd2; listo = 1'b1;
      repeat (3) @(negedge clk);
      chk("busy_before_rst", int'(busy), 1);
      #2 rst = 1'b1;
      #1 chk("async_rst_outputs", int'({motor_on, motor_sel, coin_pulse, busy, done, overrun, jam}), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      busy_seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (busy) busy_seen = 1;
      end
      chk("no_retrigger_after_rst", busy_seen, 0);
      listo = 1'b0;
      @(negedge clk);

      // reset during COIN_HI, then a clean sale
      start(2'b00, 2'd2);
      chk("coin_hi_before_rst", int'(coin_pulse), 1);
      #1 rst = 1'b1;
      #1 chk("rst_drops_coin", int'(coin_pulse), 0);
      chk("rst_drops_busy", int'(busy), 0);
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      start(2'b11, 2'd1);
      wait_idle();

`ifdef JAM_DETECT_EN
      // motor never reaches home: jam, no done, stuck busy until reset
      motor_home = 1'b0;
      @(negedge clk);
      producto = 2'b01; cambio = 2'd1; listo = 1'b1;
      @(negedge clk);
      listo = 1'b0;
      repeat (15) @(negedge clk);
      chk("jam_flag", int'(jam), 1);
      chk("jam_busy", int'(busy), 1);
      chk("jam_no_coin", int'(coin_pulse), 0);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      motor_home = 1'b1;
      chk("jam_cleared", int'(jam), 0);
`endif

      chk("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
